cook_timer: RTL

COOK_TIMER -- requirements
Module: cook_timer

---
 rtl/microwave_pkg.sv | 19 +
 rtl/bcd_down_digit.sv | 43 ++++
 rtl/cook_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the cook timer: FSM state encoding, BCD digit width and reload constants.
package microwave_pkg;

    // IDLE: time 00:00 | ARMED: time set, paused | RUN: counting down | DONE: countdown expired
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCD_W      = 4;
    localparam int SEC_RELOAD = 59;

    localparam logic [BCD_W-1:0] BCD_MAX         = BCD_W'(9);
    localparam logic [BCD_W-1:0] SEC_TENS_RELOAD = BCD_W'(SEC_RELOAD / 10);
    localparam logic [BCD_W-1:0] SEC_ONES_RELOAD = BCD_W'(SEC_RELOAD % 10);

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD display digit: synchronous load, keypad shift-in, and decrement with borrow chaining.
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter logic [BCD_W-1:0] RELOAD = BCD_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             shift_i,
    input  logic [BCD_W-1:0] shift_val_i,
    input  logic             borrow_i,
    output logic             borrow_o,
    output logic [BCD_W-1:0] value_o
);

    logic [BCD_W-1:0] value_q;
    logic [BCD_W-1:0] value_d;

    assign borrow_o = borrow_i && (value_q == '0);
    assign value_o  = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (shift_i) begin
            value_d = shift_val_i;
        end else if (borrow_i) begin
            value_d = (value_q == '0) ? RELOAD : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad entry, MM:SS BCD countdown gated by mag_on, done indication.
// Define COOK_TIMER_DONE_HOLD_EN to hold timer_done high in DONE instead of pulsing it.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mag_on,
    input  logic             clearn,
    input  logic             digit_valid,
    input  logic [BCD_W-1:0] digit,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             timer_done,
    output logic             running
);

    localparam int            PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          timer_done_q;
    logic          running_q;

    logic time_zero;
    logic time_one;
    logic run_en;
    logic tick;
    logic entry;
    logic entry_nonzero;
    logic clr;
    logic b_so;
    logic b_st;
    logic b_mo;
    logic borrow_unused;

    assign time_zero = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == '0);
    assign time_one  = (min_tens == '0) && (min_ones == '0) && (sec_tens == '0) && (sec_ones == BCD_W'(1));

    // The mag_on cycle that launches RUN from ARMED already counts toward the second
    assign run_en        = mag_on && (state_q != ST_IDLE) && !time_zero;
    assign clr           = !clearn;
    assign tick          = clearn && run_en && (presc_q == PRESC_TOP);
    assign entry         = clearn && digit_valid && !mag_on && (digit <= BCD_MAX) && (state_q != ST_RUN);
    assign entry_nonzero = (min_ones != '0) || (sec_tens != '0) || (sec_ones != '0) || (digit != '0);

    bcd_down_digit #(.RELOAD(SEC_ONES_RELOAD)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .load_i(clr), .load_val_i('0),
        .shift_i(entry), .shift_val_i(digit),
        .borrow_i(tick), .borrow_o(b_so), .value_o(sec_ones)
    );

    bcd_down_digit #(.RELOAD(SEC_TENS_RELOAD)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .load_i(clr), .load_val_i('0),
        .shift_i(entry), .shift_val_i(sec_ones),
        .borrow_i(b_so), .borrow_o(b_st), .value_o(sec_tens)
    );

    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .load_i(clr), .load_val_i('0),
        .shift_i(entry), .shift_val_i(sec_tens),
        .borrow_i(b_st), .borrow_o(b_mo), .value_o(min_ones)
    );

    // Ticks never occur at 00:00, so the top digit's borrow-out cannot fire
    bcd_down_digit #(.RELOAD(BCD_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .load_i(clr), .load_val_i('0),
        .shift_i(entry), .shift_val_i(min_ones),
        .borrow_i(b_mo), .borrow_o(borrow_unused), .value_o(min_tens)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            timer_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else if (clr) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            timer_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else if (tick) begin
            presc_q      <= '0;
            state_q      <= time_one ? ST_DONE : ST_RUN;
            timer_done_q <= time_one;
            running_q    <= !time_one;
        end else if (entry) begin
            presc_q      <= '0;
            state_q      <= entry_nonzero ? ST_ARMED : ST_IDLE;
            timer_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
`ifdef COOK_TIMER_DONE_HOLD_EN
            timer_done_q <= timer_done_q;
`else
            timer_done_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (mag_on) begin
                        state_q      <= ST_DONE;
                        timer_done_q <= 1'b1;
                    end
                end
                ST_ARMED, ST_DONE: begin
                    if (run_en) begin
                        state_q   <= ST_RUN;
                        presc_q   <= presc_q + 1'b1;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (mag_on) begin
                        presc_q <= presc_q + 1'b1;
                    end else begin
                        state_q   <= ST_ARMED;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign timer_done = timer_done_q;
    assign running    = running_q;

endmodule
